// File: rtl/dbg_run_ctrl.sv
// dbg_run_ctrl: debug run-control sequencer for the five-stage Mini-RISC-V core.
// Drives the pipeline freeze (dbg) from host halt/resume/step commands, a single
// hardware PC breakpoint and an optional halt-on-ecall. It also keeps a count of
// instructions that leave decode while the core is running or stepping.
module dbg_run_ctrl #(
  parameter int ADDR_W       = 16,
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              halt_req,
  input  logic              resume_req,
  input  logic              step_req,
  input  logic [7:0]        step_cnt,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              ecall_halt_en,
  input  logic [ADDR_W-1:0] IF_ID_pres_addr,
  input  logic              ecall,
  input  logic              hz,
  input  logic              mem_hold,
  input  logic              instret_clr,
  output logic              dbg,
  output logic              halted,
  output logic [1:0]        halt_cause,
  output logic              evt_halted,
  output logic [31:0]       instret
);

  // Run-control states
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  // Halt cause encodings
  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_HOST  = 2'b01;
  localparam logic [1:0] CAUSE_BP    = 2'b10;
  localparam logic [1:0] CAUSE_ECALL = 2'b11;

  // State taken out of reset
  localparam logic [1:0] ST_RESET = RESET_HALTED ? ST_HALT : ST_RUN;

  logic [1:0]  state_reg, state_next;
  logic [7:0]  step_ctr_reg, step_ctr_next;
  logic        skip_reg, skip_next;
  logic [1:0]  cause_reg, cause_next;
  logic [31:0] instret_reg, instret_next;
  logic        evt_reg, evt_next;

  logic        bp_match;
  logic        ecall_match;
  logic        trap_hit;
  logic        dbg_int;
  logic        adv;
  logic        leave_halt;

  // Trap detection: breakpoint / ecall match, masked by skip so a resumed
  // instruction sitting on the breakpoint PC can leave decode once. Reset also
  // masks it so dbg holds its reset value while Rst is asserted.
  always_comb begin
    bp_match    = bp_en && (IF_ID_pres_addr == bp_addr);
    ecall_match = ecall_halt_en && ecall;
    trap_hit    = Rst && !skip_reg && (bp_match || ecall_match);
  end

  // Mealy freeze: in RUN the trap stalls the matching instruction in decode the
  // same cycle, so it never reaches ID/EX.
  always_comb begin
    dbg_int = 1'b1;
    case (state_reg)
      ST_RUN:  dbg_int = trap_hit;
      ST_HALT: dbg_int = 1'b1;
      ST_STEP: dbg_int = 1'b0;
      default: dbg_int = 1'b1;
    endcase
  end

  // An instruction leaves decode when nothing is holding the pipeline.
  always_comb begin
    adv        = !dbg_int && !mem_hold && !hz;
    leave_halt = (state_reg == ST_HALT) && (step_req || resume_req);
  end

  // Next-state, step counter, skip and halt-cause logic.
  always_comb begin
    state_next    = state_reg;
    step_ctr_next = step_ctr_reg;
    cause_next    = cause_reg;
    skip_next     = skip_reg;

    // The first instruction that advances consumes the skip.
    if (adv) begin
      skip_next = 1'b0;
    end

    case (state_reg)
      ST_RUN: begin
        // Host halt outranks a trap; resume/step have nothing to do here.
        if (halt_req) begin
          state_next = ST_HALT;
          cause_next = CAUSE_HOST;
        end else if (trap_hit) begin
          state_next = ST_HALT;
          cause_next = bp_match ? CAUSE_BP : CAUSE_ECALL;
        end
      end

      ST_HALT: begin
        // Step wins over a simultaneous resume; a zero count means one step.
        if (step_req) begin
          state_next    = ST_STEP;
          step_ctr_next = (step_cnt == 8'd0) ? 8'd1 : step_cnt;
        end else if (resume_req) begin
          state_next = ST_RUN;
        end
        // Leaving a trap-caused halt must not immediately re-trap on the same PC.
        if (leave_halt && cause_reg[1]) begin
          skip_next = 1'b1;
        end
      end

      ST_STEP: begin
        // Breakpoints and ecall are deliberately ignored while stepping.
        if (halt_req) begin
          state_next = ST_HALT;
          cause_next = CAUSE_HOST;
        end else if (adv) begin
          step_ctr_next = step_ctr_reg - 8'd1;
          // Treat a (never expected) zero counter as the last step too.
          if (step_ctr_reg <= 8'd1) begin
            state_next = ST_HALT;
          end
        end
      end

      default: begin
        // Unreachable encoding: park safely in HALT.
        state_next = ST_HALT;
      end
    endcase
  end

  // Halt-entry event and retire counter next values.
  always_comb begin
    evt_next = (state_reg != ST_HALT) && (state_next == ST_HALT);

    instret_next = instret_reg;
    if (instret_clr) begin
      instret_next = 32'd0;
    end else if (adv && (state_reg != ST_HALT)) begin
      instret_next = instret_reg + 32'd1;
    end
  end

  // Control-state registers.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_reg    <= ST_RESET;
      step_ctr_reg <= 8'd0;
      skip_reg     <= 1'b0;
      cause_reg    <= CAUSE_NONE;
    end else begin
      state_reg    <= state_next;
      step_ctr_reg <= step_ctr_next;
      skip_reg     <= skip_next;
      cause_reg    <= cause_next;
    end
  end

  // One-cycle pulse on each entry into HALT.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      evt_reg <= 1'b0;
    end else begin
      evt_reg <= evt_next;
    end
  end

  // Retired-instruction counter; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      instret_reg <= 32'd0;
    end else begin
      instret_reg <= instret_next;
    end
  end

  // Output mapping; halted comes straight from the state register.
  always_comb begin
    dbg        = dbg_int;
    halted     = (state_reg == ST_HALT);
    halt_cause = cause_reg;
    evt_halted = evt_reg;
    instret    = instret_reg;
  end

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// tb_dbg_run_ctrl: directed bench for dbg_run_ctrl. Two instances share all
// inputs: u_run leaves reset running, u_hlt leaves reset halted. Inputs change
// just after the falling edge and outputs are sampled 1 time unit later.
module tb_dbg_run_ctrl;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              halt_req, resume_req, step_req;
  logic [7:0]        step_cnt;
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
  logic              ecall_halt_en;
  logic [ADDR_W-1:0] pc;
  logic              ecall, hz, mem_hold, instret_clr;

  logic        dbg0, halted0, evt0;
  logic [1:0]  cause0;
  logic [31:0] instret0;
  logic        dbg1, halted1, evt1;
  logic [1:0]  cause1;
  logic [31:0] instret1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dbg_run_ctrl #(.ADDR_W(ADDR_W), .RESET_HALTED(1'b0)) u_run (
    .clk(clk), .Rst(rst_n), .halt_req(halt_req), .resume_req(resume_req),
    .step_req(step_req), .step_cnt(step_cnt), .bp_en(bp_en), .bp_addr(bp_addr),
    .ecall_halt_en(ecall_halt_en), .IF_ID_pres_addr(pc), .ecall(ecall), .hz(hz),
    .mem_hold(mem_hold), .instret_clr(instret_clr), .dbg(dbg0), .halted(halted0),
    .halt_cause(cause0), .evt_halted(evt0), .instret(instret0)
  );

  dbg_run_ctrl #(.ADDR_W(ADDR_W), .RESET_HALTED(1'b1)) u_hlt (
    .clk(clk), .Rst(rst_n), .halt_req(halt_req), .resume_req(resume_req),
    .step_req(step_req), .step_cnt(step_cnt), .bp_en(bp_en), .bp_addr(bp_addr),
    .ecall_halt_en(ecall_halt_en), .IF_ID_pres_addr(pc), .ecall(ecall), .hz(hz),
    .mem_hold(mem_hold), .instret_clr(instret_clr), .dbg(dbg1), .halted(halted1),
    .halt_cause(cause1), .evt_halted(evt1), .instret(instret1)
  );

  // Advance to the next falling edge and drop all one-cycle pulses.
  task automatic next_cyc();
    @(negedge clk);
    halt_req    = 1'b0;
    resume_req  = 1'b0;
    step_req    = 1'b0;
    instret_clr = 1'b0;
  endtask

  task automatic test_reset();
    bp_en = 1'b1; bp_addr = pc;   // a matching PC must not freeze during reset
    @(negedge clk); #1;
    n_checks++; if (halted0 !== 1'b0) $display("FAIL rst_halted_run: got %0b want 0", halted0); else n_pass++;
    n_checks++; if (dbg0 !== 1'b0) $display("FAIL rst_dbg_run: got %0b want 0", dbg0); else n_pass++;
    n_checks++; if (cause0 !== 2'b00) $display("FAIL rst_cause: got %b want 00", cause0); else n_pass++;
    n_checks++; if (evt0 !== 1'b0) $display("FAIL rst_evt: got %0b want 0", evt0); else n_pass++;
    n_checks++; if (instret0 !== 32'd0) $display("FAIL rst_instret: got %0d want 0", instret0); else n_pass++;
    n_checks++; if (halted1 !== 1'b1) $display("FAIL rst_halted_hlt: got %0b want 1", halted1); else n_pass++;
    n_checks++; if (dbg1 !== 1'b1) $display("FAIL rst_dbg_hlt: got %0b want 1", dbg1); else n_pass++;
    bp_en = 1'b0;
    #1 rst_n = 1'b1;
    next_cyc(); #1;
    n_checks++; if (instret0 !== 32'd1) $display("FAIL rst_first_adv: instret got %0d want 1", instret0); else n_pass++;
    n_checks++; if (instret1 !== 32'd0) $display("FAIL rst_hlt_no_adv: instret got %0d want 0", instret1); else n_pass++;
    $display("test_reset: reset values and first advance checked");
  endtask

  task automatic test_breakpoint();
    next_cyc(); instret_clr = 1'b1; pc = 16'h0030; #1;
    next_cyc(); pc = 16'h0038; bp_en = 1'b1; bp_addr = 16'h0040; #1;
    n_checks++; if (dbg0 !== 1'b0) $display("FAIL bp_no_hit_38: dbg got %0b want 0", dbg0); else n_pass++;
    next_cyc(); pc = 16'h003C; #1;
    next_cyc(); pc = 16'h0040; #1;
    n_checks++; if (dbg0 !== 1'b1) $display("FAIL bp_dbg_same_cycle: dbg got %0b want 1", dbg0); else n_pass++;
    n_checks++; if (halted0 !== 1'b0) $display("FAIL bp_halted_not_yet: got %0b want 0", halted0); else n_pass++;
    next_cyc(); #1;
    n_checks++; if (halted0 !== 1'b1) $display("FAIL bp_halted: got %0b want 1", halted0); else n_pass++;
    n_checks++; if (cause0 !== 2'b10) $display("FAIL bp_cause: got %b want 10", cause0); else n_pass++;
    n_checks++; if (evt0 !== 1'b1) $display("FAIL bp_evt_pulse: got %0b want 1", evt0); else n_pass++;
    n_checks++; if (instret0 !== 32'd2) $display("FAIL bp_instret: got %0d want 2", instret0); else n_pass++;
    next_cyc(); #1;
    n_checks++; if (evt0 !== 1'b0) $display("FAIL bp_evt_one_cycle: got %0b want 0", evt0); else n_pass++;
    next_cyc(); resume_req = 1'b1; #1;
    n_checks++; if (dbg0 !== 1'b1) $display("FAIL bp_resume_cycle_dbg: got %0b want 1", dbg0); else n_pass++;
    next_cyc(); #1;
    n_checks++; if (dbg0 !== 1'b0) $display("FAIL bp_skip_dbg: got %0b want 0", dbg0); else n_pass++;
    next_cyc(); pc = 16'h0044; #1;
    n_checks++; if (halted0 !== 1'b0) $display("FAIL bp_no_rehalt: halted got %0b want 0", halted0); else n_pass++;
    next_cyc(); pc = 16'h0040; #1;
    n_checks++; if (dbg0 !== 1'b1) $display("FAIL bp_rehit_dbg: got %0b want 1", dbg0); else n_pass++;
    next_cyc(); #1;
    n_checks++; if (halted0 !== 1'b1 || evt0 !== 1'b1) $display("FAIL bp_rehit_halt: halted=%0b evt=%0b want 1/1", halted0, evt0); else n_pass++;
    n_checks++; if (instret0 !== 32'd4) $display("FAIL bp_rehit_instret: got %0d want 4", instret0); else n_pass++;
    $display("test_breakpoint: hit, resume past breakpoint, re-hit");
  endtask

  task automatic test_step_stall();
    int n_low, n_adv, n_evt;
    next_cyc(); bp_en = 1'b0; instret_clr = 1'b1; #1;
    next_cyc(); step_req = 1'b1; step_cnt = 8'd3; #1;
    n_checks++; if (dbg0 !== 1'b1) $display("FAIL step_req_cycle_dbg: got %0b want 1", dbg0); else n_pass++;
    n_low = 0; n_adv = 0; n_evt = 0;
    for (int i = 0; i < 7; i++) begin
      next_cyc(); mem_hold = (i == 1 || i == 2); #1;
      if (!dbg0) n_low++;
      if (!dbg0 && !mem_hold && !hz) n_adv++;
      if (evt0) n_evt++;
    end
    mem_hold = 1'b0;
    n_checks++; if (n_low != 5) $display("FAIL step3_dbg_low: got %0d cycles want 5", n_low); else n_pass++;
    n_checks++; if (n_adv != 3) $display("FAIL step3_adv: got %0d want 3", n_adv); else n_pass++;
    n_checks++; if (n_evt != 1) $display("FAIL step3_evt: got %0d pulses want 1", n_evt); else n_pass++;
    n_checks++; if (instret0 !== 32'd3) $display("FAIL step3_instret: got %0d want 3", instret0); else n_pass++;
    n_checks++; if (halted0 !== 1'b1 || cause0 !== 2'b10) $display("FAIL step3_end: halted=%0b cause=%b want 1/10", halted0, cause0); else n_pass++;
    $display("test_step_stall: step 3 with 2-cycle mem_hold");
  endtask

  task automatic test_zero_priority();
    int n_low;
    next_cyc(); instret_clr = 1'b1; #1;
    next_cyc(); step_req = 1'b1; resume_req = 1'b1; step_cnt = 8'd0; #1;
    n_low = 0;
    for (int i = 0; i < 5; i++) begin
      next_cyc(); #1;
      if (!dbg0) n_low++;
    end
    n_checks++; if (n_low != 1) $display("FAIL zero_step_low: got %0d cycles want 1", n_low); else n_pass++;
    n_checks++; if (instret0 !== 32'd1) $display("FAIL zero_step_instret: got %0d want 1", instret0); else n_pass++;
    n_checks++; if (halted0 !== 1'b1) $display("FAIL zero_step_halted: got %0b want 1", halted0); else n_pass++;
    $display("test_zero_priority: step_cnt=0 with simultaneous resume");
  endtask

  task automatic test_halt_during_step();
    int n_low;
    next_cyc(); instret_clr = 1'b1; #1;
    next_cyc(); step_req = 1'b1; step_cnt = 8'd10; #1;
    n_low = 0;
    for (int i = 0; i < 4; i++) begin
      next_cyc(); #1;
      if (!dbg0) n_low++;
    end
    n_checks++; if (n_low != 4) $display("FAIL hstep_adv: got %0d want 4", n_low); else n_pass++;
    next_cyc(); halt_req = 1'b1; hz = 1'b1; #1;
    next_cyc(); hz = 1'b0; #1;
    n_checks++; if (halted0 !== 1'b1 || dbg0 !== 1'b1) $display("FAIL hstep_halt: halted=%0b dbg=%0b want 1/1", halted0, dbg0); else n_pass++;
    n_checks++; if (cause0 !== 2'b01) $display("FAIL hstep_cause: got %b want 01", cause0); else n_pass++;
    n_checks++; if (instret0 !== 32'd4) $display("FAIL hstep_instret: got %0d want 4", instret0); else n_pass++;
    n_checks++; if (evt0 !== 1'b1) $display("FAIL hstep_evt: got %0b want 1", evt0); else n_pass++;
    $display("test_halt_during_step: halt_req after 4 steps");
  endtask

  task automatic test_ecall();
    next_cyc(); resume_req = 1'b1; #1;
    next_cyc(); ecall = 1'b1; ecall_halt_en = 1'b0; #1;
    n_checks++; if (dbg0 !== 1'b0) $display("FAIL ecall_dis_dbg: got %0b want 0", dbg0); else n_pass++;
    next_cyc(); #1;
    n_checks++; if (halted0 !== 1'b0) $display("FAIL ecall_dis_halt: got %0b want 0", halted0); else n_pass++;
    next_cyc(); ecall_halt_en = 1'b1; #1;
    n_checks++; if (dbg0 !== 1'b1) $display("FAIL ecall_dbg: got %0b want 1", dbg0); else n_pass++;
    next_cyc(); #1;
    n_checks++; if (halted0 !== 1'b1 || cause0 !== 2'b11) $display("FAIL ecall_cause: halted=%0b cause=%b want 1/11", halted0, cause0); else n_pass++;
    // Breakpoint and ecall together: breakpoint cause wins.
    next_cyc(); resume_req = 1'b1; ecall = 1'b0; #1;
    next_cyc(); #1;
    n_checks++; if (dbg0 !== 1'b0) $display("FAIL ecall_resume_dbg: got %0b want 0", dbg0); else n_pass++;
    next_cyc(); ecall = 1'b1; bp_en = 1'b1; bp_addr = pc; #1;
    n_checks++; if (dbg0 !== 1'b1) $display("FAIL both_dbg: got %0b want 1", dbg0); else n_pass++;
    next_cyc(); #1;
    n_checks++; if (cause0 !== 2'b10) $display("FAIL both_cause: got %b want 10", cause0); else n_pass++;
    // Host halt from RUN.
    next_cyc(); resume_req = 1'b1; ecall = 1'b0; bp_en = 1'b0; ecall_halt_en = 1'b0; #1;
    next_cyc(); #1;
    n_checks++; if (halted0 !== 1'b0) $display("FAIL host_run: halted got %0b want 0", halted0); else n_pass++;
    next_cyc(); halt_req = 1'b1; #1;
    n_checks++; if (dbg0 !== 1'b0) $display("FAIL host_req_cycle_dbg: got %0b want 0", dbg0); else n_pass++;
    next_cyc(); #1;
    n_checks++; if (halted0 !== 1'b1 || dbg0 !== 1'b1 || cause0 !== 2'b01 || evt0 !== 1'b1)
      $display("FAIL host_halt: halted=%0b dbg=%0b cause=%b evt=%0b want 1/1/01/1", halted0, dbg0, cause0, evt0); else n_pass++;
    // A halt command while already halted is dropped.
    next_cyc(); halt_req = 1'b1; #1;
    next_cyc(); #1;
    n_checks++; if (evt0 !== 1'b0) $display("FAIL halt_in_halt_evt: got %0b want 0", evt0); else n_pass++;
    $display("test_ecall: ecall enable, bp-over-ecall priority, host halt");
  endtask

  task automatic test_instret_clr_adv();
    next_cyc(); resume_req = 1'b1; instret_clr = 1'b1; #1;
    next_cyc(); #1;
    n_checks++; if (instret0 !== 32'd0) $display("FAIL clr_halted: got %0d want 0", instret0); else n_pass++;
    next_cyc(); instret_clr = 1'b1; #1;
    n_checks++; if (instret0 !== 32'd1) $display("FAIL clr_pre_adv: got %0d want 1", instret0); else n_pass++;
    next_cyc(); #1;
    n_checks++; if (instret0 !== 32'd0) $display("FAIL clr_with_adv: got %0d want 0", instret0); else n_pass++;
    next_cyc(); #1;
    n_checks++; if (instret0 !== 32'd1) $display("FAIL clr_then_adv: got %0d want 1", instret0); else n_pass++;
    $display("test_instret_clr_adv: clear has priority over increment");
  endtask

  task automatic test_reset_mid_step();
    next_cyc(); rst_n = 1'b0; #2 rst_n = 1'b1;
    next_cyc(); step_req = 1'b1; step_cnt = 8'd10; #1;
    n_checks++; if (dbg1 !== 1'b1) $display("FAIL rms_halted_dbg: got %0b want 1", dbg1); else n_pass++;
    next_cyc(); #1;
    n_checks++; if (dbg1 !== 1'b0) $display("FAIL rms_stepping_dbg: got %0b want 0", dbg1); else n_pass++;
    next_cyc(); #1;
    next_cyc(); #1;
    n_checks++; if (instret1 !== 32'd2) $display("FAIL rms_pre_instret: got %0d want 2", instret1); else n_pass++;
    #2 rst_n = 1'b0; #1;
    n_checks++; if (halted1 !== 1'b1 || dbg1 !== 1'b1) $display("FAIL rms_async: halted=%0b dbg=%0b want 1/1", halted1, dbg1); else n_pass++;
    n_checks++; if (instret1 !== 32'd0 || cause1 !== 2'b00 || evt1 !== 1'b0)
      $display("FAIL rms_clear: instret=%0d cause=%b evt=%0b want 0/00/0", instret1, cause1, evt1); else n_pass++;
    n_checks++; if (halted0 !== 1'b0 || dbg0 !== 1'b0) $display("FAIL rms_run_inst: halted=%0b dbg=%0b want 0/0", halted0, dbg0); else n_pass++;
    next_cyc(); rst_n = 1'b1; #1;
    next_cyc(); #1;
    n_checks++; if (halted1 !== 1'b1 || dbg1 !== 1'b1 || instret1 !== 32'd0)
      $display("FAIL rms_after: halted=%0b dbg=%0b instret=%0d want 1/1/0", halted1, dbg1, instret1); else n_pass++;
    $display("test_reset_mid_step: async reset while stepping");
  endtask

  initial begin
    rst_n = 1'b0;
    halt_req = 1'b0; resume_req = 1'b0; step_req = 1'b0; step_cnt = 8'd0;
    bp_en = 1'b0; bp_addr = '0; ecall_halt_en = 1'b0; pc = 16'h0030;
    ecall = 1'b0; hz = 1'b0; mem_hold = 1'b0; instret_clr = 1'b0;

    test_reset();
    test_breakpoint();
    test_step_stall();
    test_zero_priority();
    test_halt_during_step();
    test_ecall();
    test_instret_clr_adv();
    test_reset_mid_step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
